// File: rtl/div_share_ctrl_pkg.sv
// Shared definitions for the divider-sharing controller: FSM state
// encoding, status codes returned to requesters and default sizing.
package div_share_ctrl_pkg;

    // Default operand width and WAIT-state watchdog limit.
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 31;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Status codes presented on err0/err1.
    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/div_rr_pick.sv
// Two-way round-robin selector. pointer = 0 favours requester 0,
// pointer = 1 favours requester 1. Only consulted when both request.
module div_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic grant_valid,
    output logic grant_id
);

    // Pick a winner: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = pointer;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one signed sequential divider between two requesters.
// A round-robin grant latches the winner's operands, screens them for
// divide-by-zero and signed overflow, launches the divider, waits for
// done under a watchdog and returns quotient/remainder/status with an ack.
//
// Handshake: a requester raises reqN with stable aN/bN and holds them
// until ackN. ackN is a one-cycle pulse during which qN/rN/errN are
// valid (they stay valid until that requester's next ack). The requester
// drops reqN the cycle after ackN; a req still high when the sequencer is
// back in IDLE is treated as a fresh request. On the divider side
// div_start is a one-cycle pulse with div_a/div_b stable; div_done is a
// one-cycle pulse with div_q/div_r valid, and is only observed in WAIT.
module div_share_ctrl
    import div_share_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] r0,
    output logic [1:0]       err0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] r1,
    output logic [1:0]       err1,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int               CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    TMO_CNT  = CW'(TIMEOUT);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_winner;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic [CW-1:0]    r_wdog;

    logic [WIDTH-1:0] r_q0;
    logic [WIDTH-1:0] r_r0;
    logic [1:0]       r_err0;
    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_r1;
    logic [1:0]       r_err1;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_is_div0;
    logic             w_is_ovf;
    logic [CW-1:0]    w_wdog_inc;
    logic             w_wdog_expire;

    // Result write-back strobe shared by both requester banks.
    logic             w_upd_en;
    logic             w_upd_qr;
    logic             w_upd_id;
    logic [WIDTH-1:0] w_upd_q;
    logic [WIDTH-1:0] w_upd_r;
    logic [1:0]       w_upd_err;

    div_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .pointer     (r_ptr),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_sel_a       = w_grant_id ? a1 : a0;
    assign w_sel_b       = w_grant_id ? b1 : b0;
    assign w_is_div0     = (w_sel_b == '0);
    assign w_is_ovf      = (w_sel_a == MOST_NEG) && (w_sel_b == '1);
    assign w_wdog_inc    = r_wdog + CW'(1);
    assign w_wdog_expire = (w_wdog_inc == TMO_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; screened-out operands skip the divider entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    if (w_is_div0 || w_is_ovf) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                // done has priority over a coincident watchdog expiry
                if (div_done || w_wdog_expire) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Work out which result (if any) is written into a requester bank this cycle.
    always_comb begin
        w_upd_en  = 1'b0;
        w_upd_qr  = 1'b0;
        w_upd_id  = r_winner;
        w_upd_q   = '0;
        w_upd_r   = '0;
        w_upd_err = ERR_OK;
        case (r_state)
            ST_IDLE: begin
                // Screening failures report status only; q/r keep their old values.
                w_upd_id = w_grant_id;
                if (w_grant_valid && w_is_div0) begin
                    w_upd_en  = 1'b1;
                    w_upd_err = ERR_DIV0;
                end else if (w_grant_valid && w_is_ovf) begin
                    w_upd_en  = 1'b1;
                    w_upd_err = ERR_OVF;
                end
            end
            ST_WAIT: begin
                if (div_done) begin
                    w_upd_en  = 1'b1;
                    w_upd_qr  = 1'b1;
                    w_upd_q   = div_q;
                    w_upd_r   = div_r;
                    w_upd_err = ERR_OK;
                end else if (w_wdog_expire) begin
                    w_upd_en  = 1'b1;
                    w_upd_qr  = 1'b1;
                    w_upd_err = ERR_TMO;
                end
            end
            default: begin
            end
        endcase
    end

    // Grant bookkeeping, latched divider operands, watchdog and pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= 1'b0;
            r_winner <= 1'b0;
            r_div_a  <= '0;
            r_div_b  <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_winner <= w_grant_id;
                        r_div_a  <= w_sel_a;
                        r_div_b  <= w_sel_b;
                    end
                end
                ST_LAUNCH: r_wdog <= '0;
                ST_WAIT: begin
                    if (!div_done) begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                ST_RESP: r_ptr <= ~r_winner;
                default: begin
                end
            endcase
        end
    end

    // Requester 0 result bank; only written when requester 0 is the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q0   <= '0;
            r_r0   <= '0;
            r_err0 <= ERR_OK;
        end else if (w_upd_en && !w_upd_id) begin
            r_err0 <= w_upd_err;
            if (w_upd_qr) begin
                r_q0 <= w_upd_q;
                r_r0 <= w_upd_r;
            end
        end
    end

    // Requester 1 result bank; only written when requester 1 is the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1   <= '0;
            r_r1   <= '0;
            r_err1 <= ERR_OK;
        end else if (w_upd_en && w_upd_id) begin
            r_err1 <= w_upd_err;
            if (w_upd_qr) begin
                r_q1 <= w_upd_q;
                r_r1 <= w_upd_r;
            end
        end
    end

    // Moore-decoded strobes and registered result outputs.
    assign ack0      = (r_state == ST_RESP) && !r_winner;
    assign ack1      = (r_state == ST_RESP) && r_winner;
    assign div_start = (r_state == ST_LAUNCH);
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign q0        = r_q0;
    assign r0        = r_r0;
    assign err0      = r_err0;
    assign q1        = r_q1;
    assign r1        = r_r1;
    assign err1      = r_err1;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: a latency-programmable divider model on the
// divider side, directed steps plus randomized transactions on the
// requester side, and an arithmetic reference model of what each
// requester should see.
module tb_div_share_ctrl;

  localparam int W   = 8;
  localparam int TMO = 31;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1;
  logic [W-1:0] q0, r0, q1, r1;
  logic [1:0]   err0, err1;
  logic         div_start;
  logic [W-1:0] div_a, div_b;
  logic         div_done = 1'b0;
  logic [W-1:0] div_q = '0;
  logic [W-1:0] div_r = '0;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .q0(q0), .r0(r0), .err0(err0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .q1(q1), .r1(r1), .err1(err1),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Signed truncating division as plain integer arithmetic.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return '0;
    return W'(sa / sb);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return '0;
    return W'(sa % sb);
  endfunction

  // ---------------- divider model ----------------
  // dm_lat = k >= 1: done pulses in the k-th cycle after the start cycle.
  // dm_lat = 0: never answers. The model ignores rst on purpose.
  int           dm_lat   = 0;
  int           dm_cnt   = 0;
  int           n_starts = 0;
  logic [W-1:0] dm_a = '0;
  logic [W-1:0] dm_b = '0;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_start) begin
      n_starts <= n_starts + 1;
      dm_a     <= div_a;
      dm_b     <= div_b;
      if (dm_lat == 1) begin
        div_done <= 1'b1;
        div_q    <= ref_q(div_a, div_b);
        div_r    <= ref_r(div_a, div_b);
        dm_cnt   <= 0;
      end else if (dm_lat > 1) begin
        dm_cnt <= dm_lat - 1;
      end else begin
        dm_cnt <= 0;
      end
    end else if (dm_cnt == 1) begin
      div_done <= 1'b1;
      div_q    <= ref_q(dm_a, dm_b);
      div_r    <= ref_r(dm_a, dm_b);
      dm_cnt   <= 0;
    end else if (dm_cnt > 1) begin
      dm_cnt <= dm_cnt - 1;
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0] m_q[2];
  logic [W-1:0] m_r[2];
  logic [1:0]   m_err[2];
  int           m_fav;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i]   = '0;
      m_r[i]   = '0;
      m_err[i] = 2'b00;
    end
    m_fav = 0;
  endtask

  // Apply one served transaction; returns whether the divider is used and
  // after how many sampled cycles (from request) the ack is expected.
  task automatic model_apply(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int lat, output int launched, output int exp_cyc);
    if (b == 8'h00) begin
      m_err[id] = 2'b01;
      launched  = 0;
      exp_cyc   = 1;
    end else if (a == 8'h80 && b == 8'hFF) begin
      m_err[id] = 2'b10;
      launched  = 0;
      exp_cyc   = 1;
    end else begin
      launched = 1;
      if (lat >= 1 && lat <= TMO) begin
        m_q[id]   = ref_q(a, b);
        m_r[id]   = ref_r(a, b);
        m_err[id] = 2'b00;
        exp_cyc   = 2 + lat;
      end else begin
        m_q[id]   = '0;
        m_r[id]   = '0;
        m_err[id] = 2'b11;
        exp_cyc   = 2 + TMO;
      end
    end
    m_fav = (id == 0) ? 1 : 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_banks(input string tag);
    check({tag, "_q0"},   32'(q0),   32'(m_q[0]));
    check({tag, "_r0"},   32'(r0),   32'(m_r[0]));
    check({tag, "_err0"}, 32'(err0), 32'(m_err[0]));
    check({tag, "_q1"},   32'(q1),   32'(m_q[1]));
    check({tag, "_r1"},   32'(r1),   32'(m_r[1]));
    check({tag, "_err1"}, 32'(err1), 32'(m_err[1]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_any_ack(output int who);
    int cyc;
    cyc = 0;
    who = -1;
    while (who < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack0) who = 0;
      else if (ack1) who = 1;
    end
    check("ack_wait_bound", 32'(who >= 0), 32'd1);
  endtask

  // One requester alone: drive, wait for its ack, check everything.
  task automatic run_txn(input string tag, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat);
    int starts0, cyc, launched, exp_cyc;
    bit got, other;
    starts0 = n_starts;
    dm_lat  = lat;
    model_apply(id, a, b, lat, launched, exp_cyc);
    if (id == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
    else         begin a1 = a; b1 = b; req1 = 1'b1; end
    cyc   = 0;
    got   = 1'b0;
    other = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ((id == 0) ? ack0 : ack1) got = 1'b1;
      if ((id == 0) ? ack1 : ack0) other = 1'b1;
    end
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
    check({tag, "_ack_seen"},  32'(got), 32'd1);
    check({tag, "_latency"},   32'(cyc), 32'(exp_cyc));
    check({tag, "_other_ack"}, 32'(other), 32'd0);
    check({tag, "_starts"},    32'(n_starts - starts0), 32'(launched));
    check({tag, "_div_a"},     32'(div_a), 32'(a));
    check({tag, "_div_b"},     32'(div_b), 32'(b));
    check_banks(tag);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_ack_pulse"},  32'((id == 0) ? ack0 : ack1), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int           who, launched, exp_cyc, r_id, r_sel, r_lat, got_ack;
  logic [W-1:0] r_a, r_b;

  initial begin
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_start", 32'(div_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_a", 32'(div_a), 32'd0);
    check("rst_div_b", 32'(div_b), 32'd0);
    check_banks("rst");
    rst = 1'b0;
    @(negedge clk);

    // Normal division, then the two screening paths.
    run_txn("t1_norm", 0, 8'h64, 8'h07, 10);
    run_txn("t2_div0", 1, 8'h05, 8'h00, 3);
    run_txn("t3_ovf",  0, 8'h80, 8'hFF, 3);

    // Simultaneous requests from reset, then a tie with the pointer on req1.
    do_reset();
    dm_lat = 4;
    a0 = 8'h0C; b0 = 8'h03; a1 = 8'hF4; b1 = 8'h03;
    req0 = 1'b1;
    req1 = 1'b1;
    wait_any_ack(who);
    check("t4_first_winner", 32'(who), 32'(m_fav));
    model_apply(0, a0, b0, 4, launched, exp_cyc);
    check_banks("t4_first");
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    wait_any_ack(who);
    check("t4_second_winner", 32'(who), 32'(m_fav));
    model_apply(1, a1, b1, 4, launched, exp_cyc);
    check_banks("t4_second");
    req1 = 1'b0;
    wait_any_ack(who);
    check("t4_third_winner", 32'(who), 32'd0);
    model_apply(0, a0, b0, 4, launched, exp_cyc);
    check_banks("t4_third");
    req0 = 1'b0;
    @(negedge clk);

    // Watchdog: no done, done on the last allowed cycle, done one too late.
    run_txn("t5_tmo",      0, 8'h37, 8'h05, 0);
    run_txn("t5_edge_ok",  1, 8'h9C, 8'h07, TMO);
    run_txn("t5_edge_tmo", 0, 8'h11, 8'h03, TMO + 1);

    // Reset while waiting on the divider; its late done must be ignored.
    dm_lat = 6;
    a0 = 8'h50; b0 = 8'h09; req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst  = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_ack = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack0 || ack1) got_ack = 1;
    end
    check("t6_no_ack", 32'(got_ack), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_div_a", 32'(div_a), 32'd0);
    check("t6_div_b", 32'(div_b), 32'd0);
    check_banks("t6_post");
    run_txn("t6_after", 1, 8'hE7, 8'h04, 5);

    // Randomized transactions, including screened operands and timeouts.
    for (int k = 0; k < 30; k++) begin
      r_id  = $urandom_range(0, 1);
      r_a   = W'($urandom);
      r_b   = W'($urandom);
      r_sel = $urandom_range(0, 9);
      r_lat = $urandom_range(1, 12);
      if (r_sel == 0) r_b = 8'h00;
      else if (r_sel == 1) begin r_a = 8'h80; r_b = 8'hFF; end
      else if (r_sel == 2) r_lat = 0;
      run_txn("rand", r_id, r_a, r_b, r_lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
